// File: rtl/matrix_uart_pkg.sv
// matrix_uart_pkg: state encodings and constants shared by the result word
// transmitter and its byte serializer.
package matrix_uart_pkg;

   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [1:0] {
      W_IDLE,
      W_SEND,
      W_CSUM
   } word_state_t;

   typedef enum logic [1:0] {
      B_IDLE,
      B_START,
      B_DATA,
      B_STOP
   } byte_state_t;

   // Byte idx of a word counted from the most significant end (0 = [31:24]).
   function automatic logic [7:0] select_byte(input logic [31:0] w, input logic [2:0] idx);
      case (idx)
         3'd0:    select_byte = w[31:24];
         3'd1:    select_byte = w[23:16];
         3'd2:    select_byte = w[15:8];
         default: select_byte = w[7:0];
      endcase
   endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 serializer for one byte at a time. A byte is taken on
// byte_valid while idle or during the final cycle of the previous stop bit,
// which lets consecutive bytes run back-to-back with no idle gap.
module uart_byte_tx #(
   parameter int CLKS_PER_BIT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       byte_done,
   output logic       tx
);
   import matrix_uart_pkg::*;

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   byte_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;
   logic             bit_end;

   assign bit_end   = (cnt == CNT_MAX);
   assign byte_done = (state == B_STOP) && bit_end;

   // Bit timing and line state: start, eight data bits LSB first, stop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= B_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx      <= 1'b1;
      end else begin
         case (state)
            B_IDLE: begin
               tx  <= 1'b1;
               cnt <= '0;
               if (byte_valid) begin
                  state <= B_START;
                  shift <= byte_data;
                  tx    <= 1'b0;
               end
            end
            B_START: begin
               if (bit_end) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= B_DATA;
                  tx      <= shift[0];
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            B_DATA: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= B_STOP;
                     tx    <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shift   <= {1'b0, shift[7:1]};
                     tx      <= shift[1];
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            B_STOP: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (byte_valid) begin
                     state <= B_START;
                     shift <= byte_data;
                     tx    <= 1'b0;
                  end else begin
                     state <= B_IDLE;
                     tx    <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= B_IDLE;
               cnt   <= '0;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/result_word_tx.sv
// result_word_tx: streams 32-bit result matrix elements out of an 8N1 UART,
// four bytes per word, most significant byte first. frame_done marks the end
// of the word flagged by word_last.
// Optional feature: define RESULT_TX_CHECKSUM_EN to append a running XOR
// checksum byte after each frame's last word.
module result_word_tx #(
   parameter int CLOCK_FREQ = 50000000,
   parameter int BAUD_RATE  = 9600
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        word_valid,
   input  logic [31:0] word_data,
   input  logic        word_last,
   output logic        word_ready,
   output logic        uart_tx,
   output logic        busy,
   output logic        frame_done
);
   import matrix_uart_pkg::*;

   localparam int CLKS_RAW     = CLOCK_FREQ / BAUD_RATE;
   localparam int CLKS_PER_BIT = (CLKS_RAW < 2) ? 2 : CLKS_RAW;
   localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_WORD);

   word_state_t w_state;
   logic [31:0] word_reg;
   logic        last_reg;
   logic [2:0]  next_idx;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_done;

`ifdef RESULT_TX_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   // Chooses the next byte for the serializer: byte 0 straight from the input
   // on acceptance so the start bit appears one cycle later, the rest from the
   // captured word as each stop bit finishes.
   always_comb begin
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      case (w_state)
         W_IDLE: begin
            if (word_valid && word_ready) begin
               byte_valid = 1'b1;
               byte_data  = word_data[31:24];
            end
         end
         W_SEND: begin
            if (byte_done) begin
               if (next_idx != LAST_IDX) begin
                  byte_valid = 1'b1;
                  byte_data  = select_byte(word_reg, next_idx);
               end
`ifdef RESULT_TX_CHECKSUM_EN
               else if (last_reg) begin
                  byte_valid = 1'b1;
                  byte_data  = csum;
               end
`endif
            end
         end
         default: begin
            byte_valid = 1'b0;
         end
      endcase
   end

   // Word sequencer: accept a word, walk its bytes, then close the word or frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_state    <= W_IDLE;
         word_ready <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         word_reg   <= '0;
         last_reg   <= 1'b0;
         next_idx   <= '0;
      end else begin
         frame_done <= 1'b0;
         case (w_state)
            W_IDLE: begin
               word_ready <= 1'b1;
               if (word_valid && word_ready) begin
                  word_ready <= 1'b0;
                  busy       <= 1'b1;
                  word_reg   <= word_data;
                  last_reg   <= word_last;
                  next_idx   <= 3'd1;
                  w_state    <= W_SEND;
               end
            end
            W_SEND: begin
               if (byte_done) begin
                  if (next_idx != LAST_IDX) begin
                     next_idx <= next_idx + 3'd1;
                  end else begin
`ifdef RESULT_TX_CHECKSUM_EN
                     if (last_reg) begin
                        w_state <= W_CSUM;
                     end else begin
                        w_state    <= W_IDLE;
                        word_ready <= 1'b1;
                        busy       <= 1'b0;
                        frame_done <= 1'b0;
                        next_idx   <= '0;
                     end
`else
                     w_state    <= W_IDLE;
                     word_ready <= 1'b1;
                     busy       <= 1'b0;
                     frame_done <= last_reg;
                     next_idx   <= '0;
`endif
                  end
               end
            end
`ifdef RESULT_TX_CHECKSUM_EN
            W_CSUM: begin
               if (byte_done) begin
                  w_state    <= W_IDLE;
                  word_ready <= 1'b1;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                  next_idx   <= '0;
               end
            end
`endif
            default: begin
               w_state    <= W_IDLE;
               word_ready <= 1'b0;
               busy       <= 1'b0;
               next_idx   <= '0;
            end
         endcase
      end
   end

`ifdef RESULT_TX_CHECKSUM_EN
   // Running XOR of every payload byte issued; cleared once the checksum byte has gone out.
   always_ff @(posedge clk) begin
      if (rst) begin
         csum <= 8'h00;
      end else if ((w_state == W_CSUM) && byte_done) begin
         csum <= 8'h00;
      end else if (byte_valid && (next_idx != LAST_IDX)) begin
         csum <= csum ^ byte_data;
      end
   end
`endif

   uart_byte_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte_tx (
      .clk       (clk),
      .rst       (rst),
      .byte_valid(byte_valid),
      .byte_data (byte_data),
      .byte_done (byte_done),
      .tx        (uart_tx)
   );

endmodule
